// File: rtl/hex_pkg.sv
// Shared types and helpers for the hex display scan driver.
package hex_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/hex_slot_ctr.sv
// Per-slot cycle counter: strobes the end of blanking and the end of the slot.
module hex_slot_ctr #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q;

  assign blank_done_o = (cnt_q == CNT_W'(BLANK_CYC - 1));
  assign slot_done_o  = (cnt_q == CNT_W'(SCAN_DIV - 1));

  // Free-running within a slot, restarting on clear or at the last cycle of the slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || slot_done_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed eight-digit seven-segment scanner with per-frame snapshot.
// Optional brightness control is compiled in with `define HEX_DIM_EN.
module hex_scan_driver
  import hex_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 64,
  parameter int NUM_DIGITS = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
`ifdef HEX_DIM_EN
  input  logic [2:0] dim_i,
`endif
  input  logic [6:0] hex0_i,
  input  logic [6:0] hex1_i,
  input  logic [6:0] hex2_i,
  input  logic [6:0] hex3_i,
  input  logic [6:0] hex4_i,
  input  logic [6:0] hex5_i,
  input  logic [6:0] hex6_i,
  input  logic [6:0] hex7_i,
  output logic [6:0] seg_o,
  output logic [7:0] dig_o,
  output logic       frame_o
);

  if (NUM_DIGITS != 8) begin : g_chk_digits
    $error("hex_scan_driver supports exactly 8 digits");
  end
  if (SCAN_DIV < 2 || SCAN_DIV <= BLANK_CYC || BLANK_CYC < 1) begin : g_chk_timing
    $error("hex_scan_driver needs SCAN_DIV >= 2, SCAN_DIV > BLANK_CYC >= 1");
  end

  scan_state_t state_q;
  logic [2:0]  digit_q;
  seg_t        snap_q [8];
  seg_t        hex_s  [8];
  seg_t        seg_q;
  logic [7:0]  dig_q;
  logic        frame_q;
  logic        blank_done_s;
  logic        slot_done_s;
  logic        cnt_clr_s;
  logic        frame_start_s;

  assign hex_s[0] = hex0_i;
  assign hex_s[1] = hex1_i;
  assign hex_s[2] = hex2_i;
  assign hex_s[3] = hex3_i;
  assign hex_s[4] = hex4_i;
  assign hex_s[5] = hex5_i;
  assign hex_s[6] = hex6_i;
  assign hex_s[7] = hex7_i;

  assign cnt_clr_s     = !en_i || (state_q == IDLE);
  // A frame begins on enable from idle or when the last digit's slot wraps.
  assign frame_start_s = en_i && ((state_q == IDLE) ||
                         ((state_q == SHOW) && slot_done_s && (digit_q == 3'd7)));

  hex_slot_ctr #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_ctr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (cnt_clr_s),
    .blank_done_o (blank_done_s),
    .slot_done_o  (slot_done_s)
  );

`ifdef HEX_DIM_EN
  if (SCAN_DIV - BLANK_CYC < 8) begin : g_chk_dim
    $error("HEX_DIM_EN needs SCAN_DIV - BLANK_CYC >= 8");
  end

  localparam int PH_RAW = (SCAN_DIV - BLANK_CYC) / 8;
  localparam int PH_LEN = (PH_RAW < 1) ? 1 : PH_RAW;
  localparam int PH_W   = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;

  logic [PH_W-1:0] ph_cnt_q;
  logic [2:0]      phase_q;
  logic [2:0]      phase_nx_s;
  logic [2:0]      dim_q;
  logic            ph_wrap_s;
  logic            lit_s;

  // Leftover cycles beyond eight full phases stay in phase 7.
  assign ph_wrap_s  = (ph_cnt_q == PH_W'(PH_LEN - 1));
  assign phase_nx_s = (ph_wrap_s && (phase_q != 3'd7)) ? phase_q + 3'd1 : phase_q;
  assign lit_s      = (phase_nx_s <= dim_q);

  // Brightness phase tracking, restarted at the first lit cycle of every slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_cnt_q <= '0;
      phase_q  <= 3'd0;
    end else if (!en_i || (state_q != SHOW)) begin
      ph_cnt_q <= '0;
      phase_q  <= 3'd0;
    end else begin
      ph_cnt_q <= ph_wrap_s ? '0 : ph_cnt_q + PH_W'(1);
      phase_q  <= phase_nx_s;
    end
  end
`endif

  // Frame snapshot of the patterns (and brightness) so mid-frame writes cannot tear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_q <= '{default: SEG_OFF};
`ifdef HEX_DIM_EN
      dim_q  <= 3'd0;
`endif
    end else if (frame_start_s) begin
      snap_q <= hex_s;
`ifdef HEX_DIM_EN
      dim_q  <= dim_i;
`endif
    end else begin
      snap_q <= snap_q;
`ifdef HEX_DIM_EN
      dim_q  <= dim_q;
`endif
    end
  end

  // Scan FSM; outputs are set from the state being entered so they are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      digit_q <= 3'd0;
      seg_q   <= SEG_OFF;
      dig_q   <= 8'h00;
      frame_q <= 1'b0;
    end else if (!en_i) begin
      state_q <= IDLE;
      digit_q <= 3'd0;
      seg_q   <= SEG_OFF;
      dig_q   <= 8'h00;
      frame_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= BLANK;
          digit_q <= 3'd0;
          seg_q   <= SEG_OFF;
          dig_q   <= 8'h00;
          frame_q <= 1'b1;
        end
        BLANK: begin
          frame_q <= 1'b0;
          if (blank_done_s) begin
            state_q <= SHOW;
            seg_q   <= snap_q[digit_q];
            dig_q   <= onehot8(digit_q);
          end else begin
            state_q <= BLANK;
            seg_q   <= SEG_OFF;
            dig_q   <= 8'h00;
          end
        end
        SHOW: begin
          if (slot_done_s) begin
            state_q <= BLANK;
            digit_q <= digit_q + 3'd1;
            seg_q   <= SEG_OFF;
            dig_q   <= 8'h00;
            frame_q <= (digit_q == 3'd7);
          end else begin
            state_q <= SHOW;
            dig_q   <= onehot8(digit_q);
            frame_q <= 1'b0;
`ifdef HEX_DIM_EN
            seg_q   <= lit_s ? snap_q[digit_q] : SEG_OFF;
`else
            seg_q   <= snap_q[digit_q];
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          digit_q <= 3'd0;
          seg_q   <= SEG_OFF;
          dig_q   <= 8'h00;
          frame_q <= 1'b0;
        end
      endcase
    end
  end

  assign seg_o   = seg_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
Downstream consumer of the memory-mapped hex display store. Takes eight 7-bit segment patterns (hex0..hex7) and drives one shared segment bus plus eight digit enables, time-multiplexed. Each digit slot has a blanking interval to prevent ghosting. All eight patterns are snapshotted once per frame so a store mid-frame cannot tear the display.

Parameters:
SCAN_DIV, 50000, clk_i cycles per digit slot; must be ≥ 2 and > BLANK_CYC.
BLANK_CYC, 64, cycles at start of each slot with all digits off; must be ≥ 1.
NUM_DIGITS, 8, digits scanned; fixed at 8 for this revision.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
en_i  in  1  scan enable
hex0_i..hex7_i  in  7 each  segment patterns, active-low (bit 0 lights)
seg_o  out  7  shared segment bus, active-low
dig_o  out  8  digit select, one-hot, active-high
frame_o  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (async): state IDLE, digit index 0, slot counter 0, snapshot regs all 7'h7F, seg_o=7'h7F, dig_o=8'h00, frame_o=0.
- All outputs are registered. Values below are those visible after the named clock edge.
- States: IDLE, BLANK, SHOW.
- IDLE: seg_o=7'h7F, dig_o=0. On the edge sampling en_i=1: go to BLANK, digit=0, cnt=0, load all 8 snapshots from hex*_i, frame_o=1.
- BLANK: dig_o=0, seg_o=7'h7F.
  - cnt increments each cycle.
  - When cnt reaches BLANK_CYC-1, go to SHOW on the next edge.
- SHOW: dig_o = 1<<digit, seg_o = snap[digit].
  - When cnt reaches SCAN_DIV-1: cnt←0, digit←digit+1 (wraps 7→0), go to BLANK.
- Slot length is exactly SCAN_DIV cycles: BLANK_CYC blank, SCAN_DIV-BLANK_CYC lit.
- Frame period is 8·SCAN_DIV cycles.
- Frame start (digit wrap 7→0, or entry from IDLE):
  - Snapshot reloaded on that same edge.
  - frame_o=1 for exactly that one cycle; otherwise 0.
- Snapshot only changes at frame start. Input changes mid-frame are invisible until the next frame.
- en_i deasserted in any state: next edge goes to IDLE, outputs off, cnt=0, digit=0, frame_o=0. The snapshot is retained but reloaded on the next enable.
- en_i held high: scanning is continuous, no gap between frames.
- dig_o never has more than one bit set. dig_o≠0 only in SHOW.
- Transition SHOW→BLANK (and BLANK→SHOW) has no overlap cycle: digit change always passes through ≥ BLANK_CYC cycles of dig_o=0.
- Reset asserted mid-slot: immediate return to reset values regardless of state.
- Counter width: $clog2(SCAN_DIV). Digit index: 3 bits, natural wrap.

Optional Feature:
HEX_DIM_EN
- Defined:
  - Adds input port dim_i [2:0].
  - The SHOW interval is split into 8 equal phases by a phase counter of length (SCAN_DIV-BLANK_CYC)/8, floor, minimum 1.
  - Segments are driven only while phase ≤ dim_i; otherwise seg_o=7'h7F with dig_o still asserted.
  - dim_i is sampled at frame start alongside the snapshot.
  - dim_i=7 gives full brightness; dim_i=0 lights 1/8 of SHOW.
  - Requires SCAN_DIV-BLANK_CYC ≥ 8 (elaboration assertion).
- Undefined: no dim_i port; segments lit for all of SHOW.

Decomposition:
- Package hex_pkg:
  - typedef seg_t (logic [6:0]).
  - SEG_OFF = 7'h7F.
  - Enum scan_state_t {IDLE, BLANK, SHOW}.
  - Function onehot8(idx) returning logic [7:0].
- One sub-module: hex_slot_ctr. Owns the slot counter and outputs blank_done and slot_done strobes; the FSM and snapshot stay in the top.

Test Plan (SCAN_DIV=8, BLANK_CYC=2 unless stated):
1. Reset, hex0..7 = 7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78; raise en_i.
   -> frame_o pulses once; dig_o=0 for 2 cycles, then 8'h01 with seg_o=7'h40 for 6 cycles; then 2 blank, 8'h02/7'h79 for 6; … digit 7 ends at cycle 64; frame_o pulses again at cycle 64.
2. Change hex3_i to 7'h00 while digit 1 is lit.
   -> digit 3 still shows 7'h30 this frame; shows 7'h00 in the next frame.
3. Drop en_i during digit 5 SHOW.
   -> next edge seg_o=7'h7F, dig_o=0, frame_o=0. Re-enable -> restart at digit 0 with fresh snapshot and a frame_o pulse.
4. Assert rst_ni low mid-SHOW (asynchronously, between edges).
   -> outputs 7'h7F / 8'h00 immediately, without waiting for a clock edge; snapshot reads 7'h7F after release.
5. Continuous run of 3 frames, checked every cycle.
   -> $onehot0(dig_o) holds every cycle; frame_o count = 3 over 192 cycles; no cycle where dig_o changes directly between two nonzero values.
6. HEX_DIM_EN, SCAN_DIV=18, BLANK_CYC=2, dim_i=3.
   -> each SHOW lasts 16 cycles with dig_o asserted; seg_o = pattern for the first 8 cycles, 7'h7F for the last 8.
